// File: rtl/sextium_avalon_sram_slave.sv
// Avalon-MM slave that turns 16-bit read/write requests into timed strobes for an
// external asynchronous SRAM, stalling the master with waitrequest until the access ends.
module sextium_avalon_sram_slave #(
  parameter int ADDR_W     = 16,
  parameter int READ_WAIT  = 2,
  parameter int WRITE_WAIT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       address,
  input  logic              read,
  input  logic              write,
  input  logic [15:0]       writedata,
  output logic [15:0]       readdata,
  output logic              waitrequest,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_dq_o,
  output logic              sram_dq_oe,
  input  logic [15:0]       sram_dq_i,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  localparam int MAX_WAIT = (READ_WAIT > WRITE_WAIT) ? READ_WAIT : WRITE_WAIT;
  localparam int CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_WR_SETUP, S_WR_PULSE, S_WR_HOLD, S_DONE, S_TURN
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [15:0]       readdata_q, readdata_d;
  logic              wait_q, wait_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       dq_o_q, dq_o_d;
  logic              dq_oe_q, dq_oe_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic              oor_q, oor_d;
  logic              addr_oor;
  logic              unused_addr_bit;

  // Byte-lane bit of the Avalon address has no meaning for a 16-bit word SRAM.
  assign unused_addr_bit = address[0];

  generate
    if (ADDR_W < 31) begin : g_oor
      assign addr_oor = |address[31:ADDR_W+1];
    end else begin : g_no_oor
      assign addr_oor = 1'b0;
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    readdata_d = readdata_q;
    wait_d     = wait_q;
    addr_d     = addr_q;
    dq_o_d     = dq_o_q;
    dq_oe_d    = dq_oe_q;
    ce_n_d     = ce_n_q;
    oe_n_d     = oe_n_q;
    we_n_d     = we_n_q;
    oor_d      = oor_q;
    case (state_q)
      S_IDLE: begin
        // Out-of-range accesses walk the same FSM path but never touch the chip.
        if (write) begin
          addr_d  = address[ADDR_W:1];
          dq_o_d  = writedata;
          oor_d   = addr_oor;
          ce_n_d  = addr_oor;
          dq_oe_d = !addr_oor;
          state_d = S_WR_SETUP;
        end else if (read) begin
          addr_d  = address[ADDR_W:1];
          oor_d   = addr_oor;
          ce_n_d  = addr_oor;
          oe_n_d  = addr_oor;
          cnt_d   = CNT_W'(READ_WAIT - 1);
          state_d = S_RD;
        end
      end
      S_RD: begin
        if (cnt_q == '0) begin
          readdata_d = oor_q ? 16'h0000 : sram_dq_i;
          ce_n_d     = 1'b1;
          oe_n_d     = 1'b1;
          wait_d     = 1'b0;
          state_d    = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_WR_SETUP: begin
        we_n_d  = oor_q;
        cnt_d   = CNT_W'(WRITE_WAIT - 1);
        state_d = S_WR_PULSE;
      end
      S_WR_PULSE: begin
        if (cnt_q == '0) begin
          we_n_d  = 1'b1;
          state_d = S_WR_HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_WR_HOLD: begin
        ce_n_d  = 1'b1;
        dq_oe_d = 1'b0;
        wait_d  = 1'b0;
        state_d = S_DONE;
      end
      S_DONE: begin
        wait_d  = 1'b1;
        state_d = S_TURN;
      end
      // A request still held across the ack edge is dropped here, not replayed.
      S_TURN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      readdata_q <= '0;
      wait_q     <= 1'b1;
      addr_q     <= '0;
      dq_o_q     <= '0;
      dq_oe_q    <= 1'b0;
      ce_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
      oor_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      readdata_q <= readdata_d;
      wait_q     <= wait_d;
      addr_q     <= addr_d;
      dq_o_q     <= dq_o_d;
      dq_oe_q    <= dq_oe_d;
      ce_n_q     <= ce_n_d;
      oe_n_q     <= oe_n_d;
      we_n_q     <= we_n_d;
      oor_q      <= oor_d;
    end
  end

  assign readdata    = readdata_q;
  assign waitrequest = wait_q;
  assign sram_addr   = addr_q;
  assign sram_dq_o   = dq_o_q;
  assign sram_dq_oe  = dq_oe_q;
  assign sram_ce_n   = ce_n_q;
  assign sram_oe_n   = oe_n_q;
  assign sram_we_n   = we_n_q;

endmodule

// File: tb/tb_sextium_avalon_sram_slave.sv
// Bench for sextium_avalon_sram_slave: SRAM behavioural model on the pins, directed
// cases followed by random Avalon traffic checked against a word-level reference memory.
module tb_sextium_avalon_sram_slave;

  localparam int ADDR_W = 16;
  localparam int RW     = 2;
  localparam int WW     = 2;

  logic              clk;
  logic              reset;
  logic [31:0]       address;
  logic              read;
  logic              write;
  logic [15:0]       writedata;
  logic [15:0]       readdata;
  logic              waitrequest;
  logic [ADDR_W-1:0] sram_addr;
  logic [15:0]       sram_dq_o;
  logic              sram_dq_oe;
  logic [15:0]       sram_dq_i;
  logic              sram_ce_n;
  logic              sram_oe_n;
  logic              sram_we_n;

  sextium_avalon_sram_slave #(
    .ADDR_W(ADDR_W), .READ_WAIT(RW), .WRITE_WAIT(WW)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata), .waitrequest(waitrequest),
    .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe),
    .sram_dq_i(sram_dq_i), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pin-level asynchronous SRAM: stores while CE and WE are low, drives while CE and OE are low.
  logic [15:0] sram_mem [0:65535];
  always @(posedge clk) begin
    if (!sram_ce_n && !sram_we_n && sram_dq_oe) sram_mem[sram_addr] <= sram_dq_o;
  end
  assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr] : 16'hDEAD;

  // Reference: what the memory should hold after each acknowledged access.
  logic [15:0] ref_mem [int];
  logic [15:0] exp_readdata;

  int n_cmp;
  int n_mis;

  int          first_we_cyc;
  logic [15:0] addr_at_we;
  logic [15:0] dq_at_we;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_rd(input int w);
    return ref_mem.exists(w) ? ref_mem[w] : 16'h0000;
  endfunction

  // Starts in an IDLE cycle (just after a negedge) and returns in the next IDLE cycle.
  task automatic access(input bit wr, input bit rd, input logic [31:0] addr,
                        input logic [15:0] wd, input bit hold, input string tag);
    int  n, we_lo, oe_lo, ce_lo, exp_lat, exp_we, exp_oe, exp_ce, w;
    bit  acked, oor;
    oor = (addr[31:17] != 15'd0);
    w   = int'(addr[16:1]);
    write = wr; read = rd; address = addr; writedata = wd;
    n = 0; we_lo = 0; oe_lo = 0; ce_lo = 0; acked = 0; first_we_cyc = -1;
    while (!acked && n < 40) begin
      @(negedge clk);
      n++;
      if (!sram_we_n) begin
        if (first_we_cyc < 0) begin
          first_we_cyc = n;
          addr_at_we   = sram_addr;
          dq_at_we     = sram_dq_o;
        end
        we_lo++;
      end
      if (!sram_oe_n) oe_lo++;
      if (!sram_ce_n) ce_lo++;
      if (!waitrequest) acked = 1;
    end
    exp_lat = wr ? WW + 3 : RW + 1;
    exp_we  = (wr && !oor) ? WW : 0;
    exp_oe  = (!wr && !oor) ? RW : 0;
    exp_ce  = oor ? 0 : (wr ? WW + 2 : RW);
    if (wr && !oor) ref_mem[w] = wd;
    if (!wr) exp_readdata = oor ? 16'h0000 : ref_rd(w);
    check({tag, "_latency"}, 32'(n), 32'(exp_lat));
    check({tag, "_we_cycles"}, 32'(we_lo), 32'(exp_we));
    check({tag, "_oe_cycles"}, 32'(oe_lo), 32'(exp_oe));
    check({tag, "_ce_cycles"}, 32'(ce_lo), 32'(exp_ce));
    check({tag, "_readdata"}, 32'(readdata), 32'(exp_readdata));
    if (!hold) begin write = 0; read = 0; end
    @(negedge clk);
    check({tag, "_ack_one_cycle"}, 32'(waitrequest), 32'd1);
    write = 0; read = 0;
    @(negedge clk);
    check({tag, "_no_replay"}, {sram_ce_n, sram_oe_n, sram_we_n}, 32'b111);
    $display("%s wr=%0d rd=%0d addr=0x%08h wd=0x%04h hold=%0d lat=%0d readdata=0x%04h",
             tag, wr, rd, addr, wd, hold, n, readdata);
  endtask

  bit          r_wr, r_rd, r_hold;
  int          r_kind;
  logic [31:0] r_addr;

  initial begin
    n_cmp = 0; n_mis = 0; exp_readdata = 16'h0000;
    for (int i = 0; i < 65536; i++) sram_mem[i] = 16'h0000;
    reset = 1; read = 0; write = 0; address = '0; writedata = '0;
    repeat (2) @(negedge clk);
    check("rst_waitrequest", 32'(waitrequest), 32'd1);
    check("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n}, 32'b111);
    check("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
    check("rst_readdata", 32'(readdata), 32'h0);
    check("rst_sram_addr", 32'(sram_addr), 32'h0);
    check("rst_dq_o", 32'(sram_dq_o), 32'h0);
    $display("reset released");
    reset = 0;
    @(negedge clk);

    access(1, 0, 32'h0000_0084, 16'hBEEF, 0, "wr_beef");
    check("wr_beef_addr", 32'(addr_at_we), 32'h0042);
    check("wr_beef_dq", 32'(dq_at_we), 32'hBEEF);
    check("wr_beef_setup_cycle", 32'(first_we_cyc), 32'd2);
    access(0, 1, 32'h0000_0084, 16'h0000, 0, "rd_beef");
    check("rd_beef_value", 32'(readdata), 32'hBEEF);
    access(0, 1, 32'h0000_0084, 16'h0000, 1, "rd_hold");
    access(1, 1, 32'h0000_0020, 16'h1234, 0, "rdwr_both");
    access(0, 1, 32'h0000_0020, 16'h0000, 0, "rd_1234");
    check("rd_1234_value", 32'(readdata), 32'h1234);
    access(0, 1, 32'h0002_0084, 16'h0000, 0, "rd_oor");
    access(1, 0, 32'h8000_0084, 16'hFFFF, 0, "wr_oor");
    access(0, 1, 32'h0000_0084, 16'h0000, 0, "rd_after_oor");

    // Abort a write in its first WE-low cycle.
    write = 1; address = 32'h0000_1000; writedata = 16'h5A5A;
    @(negedge clk);
    check("abort_setup_we", 32'(sram_we_n), 32'd1);
    @(negedge clk);
    check("abort_pulse_we", 32'(sram_we_n), 32'd0);
    reset = 1;
    @(negedge clk);
    check("abort_strobes", {sram_ce_n, sram_oe_n, sram_we_n}, 32'b111);
    check("abort_dq_oe", 32'(sram_dq_oe), 32'd0);
    check("abort_no_ack", 32'(waitrequest), 32'd1);
    exp_readdata = 16'h0000;
    write = 0; reset = 0;
    @(negedge clk);
    check("abort_idle_ack", 32'(waitrequest), 32'd1);
    access(0, 1, 32'h0000_0000, 16'h0000, 0, "rd_after_abort");

    for (int t = 0; t < 80; t++) begin
      r_kind = $urandom_range(0, 9);
      r_addr = {15'd0, 11'd0, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1))};
      r_hold = 1'($urandom_range(0, 1));
      if (r_kind <= 3)      begin r_wr = 1; r_rd = 0; end
      else if (r_kind <= 7) begin r_wr = 0; r_rd = 1; end
      else if (r_kind == 8) begin r_wr = 1; r_rd = 1; end
      else begin
        r_wr = 1'($urandom_range(0, 1));
        r_rd = !r_wr;
        r_addr[31:17] = 15'($urandom_range(1, 32767));
      end
      access(r_wr, r_rd, r_addr, 16'($urandom), r_hold, $sformatf("rnd%0d", t));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
